ex_mem_skid: RTL and testbench
==============================

Name: ex_mem_skid

Overview:
- Registered hand-off stage between the execute stage and the memory stage.
- On the execute side, the ALU result (including the 0/1 word from the set-less-than unit), store data and control fields are captured behind a valid/ready handshake.
- A 2-entry skid buffer is used, so upstream o_ready is a pure register output. This gives full throughput with no combinational ready path.
- A synchronous flush discards in-flight entries on branch or jump redirect.

Parameters:
- DATA_W, 32, width of ALU result and store data.
- RD_W, 5, width of destination register index.

Ports:
- i_clk  input  1  clock, rising edge.
- i_reset  input  1  asynchronous active-low reset.
- i_flush  input  1  synchronous flush, drops all buffered entries.
- i_valid  input  1  upstream entry valid.
- o_ready  output  1  stage can accept an entry this cycle.
- i_alu_result  input  DATA_W  ALU output (SLT/SLTU results arrive as 32'd0 or 32'd1).
- i_rs2_data  input  DATA_W  store data.
- i_rd_addr  input  RD_W  destination register.
- i_rd_wren  input  1  register write enable.
- i_mem_wren  input  1  store.
- i_mem_rden  input  1  load.
- i_funct3  input  3  access size and sign.
- o_valid  output  1  downstream entry valid.
- i_ready  input  1  downstream accepts.
- o_alu_result  output  DATA_W  buffered result.
- o_rs2_data  output  DATA_W  buffered store data.
- o_rd_addr  output  RD_W  buffered destination register.
- o_rd_wren  output  1  buffered write enable.
- o_mem_wren  output  1  buffered store.
- o_mem_rden  output  1  buffered load.
- o_funct3  output  3  buffered funct3.
- o_occupancy  output  2  entries held, 0 to 2.

Behaviour:
- Transfer definitions: in_fire = i_valid & o_ready; out_fire = o_valid & i_ready.
- Storage: a main register drives all o_* data outputs; a skid register sits behind it.
- State register values: EMPTY, ONE, FULL.
  - o_valid = (state != EMPTY).
  - o_ready = (state != FULL).
  - o_occupancy is 0, 1 or 2 respectively.
  - All three are decoded from registered state only.
- EMPTY:
  - in_fire: load main, go to ONE.
  - Otherwise: hold.
- ONE:
  - in_fire & out_fire: load main with the new entry, stay ONE.
  - in_fire only: load skid, go to FULL.
  - out_fire only: go to EMPTY.
  - Neither: hold.
- FULL:
  - out_fire: copy skid to main, go to ONE.
  - No in_fire is possible (o_ready = 0).
  - Otherwise: hold.
- Latency and throughput:
  - Latency is 1 cycle from in_fire to o_valid when EMPTY.
  - Throughput is 1 entry per cycle while i_ready stays high.
- Ordering is strictly FIFO; no entry is dropped or duplicated except on flush.
- Output stability: while o_valid & !i_ready, every o_* output holds its value.
- Side-effect gating: o_rd_wren, o_mem_wren and o_mem_rden are forced to 0 whenever o_valid = 0. Data outputs may hold stale values when invalid.
- Flush:
  - i_flush = 1 at a clock edge sends the state to EMPTY.
  - It overrides any simultaneous in_fire or out_fire; a coincident incoming entry is discarded.
  - Data registers are not required to clear.
- Reset:
  - i_reset = 0 clears immediately, without waiting for a clock edge, including mid-transfer.
  - State goes to EMPTY; main and skid registers go to all zero.
  - Resulting outputs: o_valid = 0, o_ready = 1, o_occupancy = 0, all data outputs 0.
- Width rules: pure storage; no arithmetic and no width change.

Test Plan:
1. Reset then stream: release i_reset, hold i_ready = 1, drive i_valid with 4 consecutive entries, i_alu_result = 0x1, 0x0, 0xFFFFFFF0, 0x7 -> o_valid rises 1 cycle later, same 4 values appear in order on consecutive cycles, o_ready stays 1 throughout.
2. Backpressure fill: i_ready = 0, push A = 0x11 then B = 0x22 -> o_occupancy goes 1 then 2, o_ready = 0 after B, o_alu_result holds 0x11; raise i_ready -> 0x11 then 0x22 emerge, o_ready returns to 1 one cycle after the first out_fire.
3. Simultaneous in/out in ONE: one entry 0x1 buffered, i_ready = 1, push 0x0 in the same cycle -> occupancy stays 1, next cycle o_alu_result = 0x0.
4. Flush: state FULL with i_valid = 1 and i_ready = 1 in the same cycle as i_flush = 1 -> next cycle o_valid = 0, o_occupancy = 0, o_rd_wren = 0, o_mem_wren = 0, o_ready = 1.
5. Async reset mid-operation: assert i_reset low between clock edges while FULL -> outputs drop immediately to o_valid = 0, o_alu_result = 0, o_ready = 1.
6. Gating: entry with i_rd_wren = 1, i_mem_wren = 1 drained, then idle -> o_rd_wren = 0 and o_mem_wren = 0 on every cycle where o_valid = 0.

Source files
------------

// File: rtl/ex_mem_skid_if.sv
// Execute-to-memory hand-off bus: upstream valid/ready, payload, downstream valid/ready and flush.
// The slave modport is the stage itself; the master modport is whatever drives and consumes it.
interface ex_mem_skid_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_W   = 5
);
  logic              i_flush;
  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_alu_result;
  logic [DATA_W-1:0] i_rs2_data;
  logic [RD_W-1:0]   i_rd_addr;
  logic              i_rd_wren;
  logic              i_mem_wren;
  logic              i_mem_rden;
  logic [2:0]        i_funct3;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_alu_result;
  logic [DATA_W-1:0] o_rs2_data;
  logic [RD_W-1:0]   o_rd_addr;
  logic              o_rd_wren;
  logic              o_mem_wren;
  logic              o_mem_rden;
  logic [2:0]        o_funct3;
  logic [1:0]        o_occupancy;

  modport slave (
    input  i_flush, i_valid, i_alu_result, i_rs2_data, i_rd_addr, i_rd_wren, i_mem_wren,
           i_mem_rden, i_funct3, i_ready,
    output o_ready, o_valid, o_alu_result, o_rs2_data, o_rd_addr, o_rd_wren, o_mem_wren,
           o_mem_rden, o_funct3, o_occupancy
  );

  modport master (
    output i_flush, i_valid, i_alu_result, i_rs2_data, i_rd_addr, i_rd_wren, i_mem_wren,
           i_mem_rden, i_funct3, i_ready,
    input  o_ready, o_valid, o_alu_result, o_rs2_data, o_rd_addr, o_rd_wren, o_mem_wren,
           o_mem_rden, o_funct3, o_occupancy
  );
endinterface

// File: rtl/ex_mem_skid.sv
// EX/MEM pipeline register built as a 2-entry skid buffer so upstream ready is a pure register
// decode; full throughput with no combinational ready path. Synchronous flush empties it.
module ex_mem_skid #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_W   = 5
) (
  input logic          i_clk,
  input logic          i_reset,
  ex_mem_skid_if.slave bus
);

  typedef struct packed {
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] rs2_data;
    logic [RD_W-1:0]   rd_addr;
    logic              rd_wren;
    logic              mem_wren;
    logic              mem_rden;
    logic [2:0]        funct3;
  } entry_t;

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e state_q;
  entry_t main_q;
  entry_t skid_q;
  entry_t in_entry;
  logic   valid;
  logic   ready;
  logic   in_fire;
  logic   out_fire;

  assign in_entry = '{
    alu_result: bus.i_alu_result,
    rs2_data:   bus.i_rs2_data,
    rd_addr:    bus.i_rd_addr,
    rd_wren:    bus.i_rd_wren,
    mem_wren:   bus.i_mem_wren,
    mem_rden:   bus.i_mem_rden,
    funct3:     bus.i_funct3
  };

  assign valid    = (state_q != StEmpty);
  assign ready    = (state_q != StFull);
  assign in_fire  = bus.i_valid & ready;
  assign out_fire = valid & bus.i_ready;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (bus.i_flush) begin
      state_q <= StEmpty;
    end else begin
      case (state_q)
        StEmpty: begin
          if (in_fire) begin
            main_q  <= in_entry;
            state_q <= StOne;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            main_q <= in_entry;
          end else if (in_fire) begin
            skid_q  <= in_entry;
            state_q <= StFull;
          end else if (out_fire) begin
            state_q <= StEmpty;
          end
        end
        StFull: begin
          if (out_fire) begin
            main_q  <= skid_q;
            state_q <= StOne;
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

  always_comb begin
    bus.o_occupancy = 2'd0;
    case (state_q)
      StOne:   bus.o_occupancy = 2'd1;
      StFull:  bus.o_occupancy = 2'd2;
      default: bus.o_occupancy = 2'd0;
    endcase
  end

  assign bus.o_valid      = valid;
  assign bus.o_ready      = ready;
  assign bus.o_alu_result = main_q.alu_result;
  assign bus.o_rs2_data   = main_q.rs2_data;
  assign bus.o_rd_addr    = main_q.rd_addr;
  assign bus.o_funct3     = main_q.funct3;
  // Side effects must never leak from a stale main register.
  assign bus.o_rd_wren    = main_q.rd_wren & valid;
  assign bus.o_mem_wren   = main_q.mem_wren & valid;
  assign bus.o_mem_rden   = main_q.mem_rden & valid;

endmodule

// File: tb/tb_ex_mem_skid.sv
// Directed bench for ex_mem_skid: a vector table stepped one clock per row, plus hand-written
// sequences for reset and asynchronous reset while full.
module tb_ex_mem_skid;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  ex_mem_skid_if #(.DATA_W(32), .RD_W(5)) bus ();

  ex_mem_skid #(.DATA_W(32), .RD_W(5)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        valid;
    logic        ready;
    logic [31:0] alu;
    logic        rdw;
    logic        mw;
    logic        e_valid;
    logic        e_ready;
    logic [1:0]  e_occ;
    logic [31:0] e_alu;
    logic        e_rdw;
    logic        e_mw;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic flush, input logic valid, input logic ready,
                              input logic [31:0] alu, input logic rdw, input logic mw,
                              input logic e_valid, input logic e_ready, input logic [1:0] e_occ,
                              input logic [31:0] e_alu, input logic e_rdw, input logic e_mw);
    vec_t v;
    v.flush = flush;     v.valid = valid;     v.ready = ready;
    v.alu = alu;         v.rdw = rdw;         v.mw = mw;
    v.e_valid = e_valid; v.e_ready = e_ready; v.e_occ = e_occ;
    v.e_alu = e_alu;     v.e_rdw = e_rdw;     v.e_mw = e_mw;
    return v;
  endfunction

  task automatic chk(input string name, input int step, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
    end
  endtask

  // Payload side fields are derived from alu so each entry is self-identifying.
  task automatic drive(input logic flush, input logic valid, input logic ready,
                       input logic [31:0] alu, input logic rdw, input logic mw);
    bus.i_flush      = flush;
    bus.i_valid      = valid;
    bus.i_ready      = ready;
    bus.i_alu_result = alu;
    bus.i_rs2_data   = alu ^ 32'hA5A5_A5A5;
    bus.i_rd_addr    = alu[4:0];
    bus.i_funct3     = alu[2:0];
    bus.i_rd_wren    = rdw;
    bus.i_mem_wren   = mw;
    bus.i_mem_rden   = ~mw;
  endtask

  task automatic check_vec(input int step, input vec_t v);
    logic [31:0] a;
    a = v.e_alu;
    chk("o_valid", step, {31'd0, bus.o_valid}, {31'd0, v.e_valid});
    chk("o_ready", step, {31'd0, bus.o_ready}, {31'd0, v.e_ready});
    chk("o_occupancy", step, {30'd0, bus.o_occupancy}, {30'd0, v.e_occ});
    chk("o_rd_wren", step, {31'd0, bus.o_rd_wren}, {31'd0, v.e_valid & v.e_rdw});
    chk("o_mem_wren", step, {31'd0, bus.o_mem_wren}, {31'd0, v.e_valid & v.e_mw});
    chk("o_mem_rden", step, {31'd0, bus.o_mem_rden}, {31'd0, v.e_valid & ~v.e_mw});
    if (v.e_valid) begin
      chk("o_alu_result", step, bus.o_alu_result, a);
      chk("o_rs2_data", step, bus.o_rs2_data, a ^ 32'hA5A5_A5A5);
      chk("o_rd_addr", step, {27'd0, bus.o_rd_addr}, {27'd0, a[4:0]});
      chk("o_funct3", step, {29'd0, bus.o_funct3}, {29'd0, a[2:0]});
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    //           fl  vl  rd  alu           rdw mw   ev  er  occ  e_alu         erdw emw
    // Stream of four with i_ready high
    vecs.push_back(mk(0, 1, 1, 32'h1,        1, 0,  1, 1, 2'd1, 32'h1,        1, 0));
    vecs.push_back(mk(0, 1, 1, 32'h0,        1, 0,  1, 1, 2'd1, 32'h0,        1, 0));
    vecs.push_back(mk(0, 1, 1, 32'hFFFFFFF0, 1, 0,  1, 1, 2'd1, 32'hFFFFFFF0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 32'h7,        1, 0,  1, 1, 2'd1, 32'h7,        1, 0));
    vecs.push_back(mk(0, 0, 1, 32'h0,        0, 0,  0, 1, 2'd0, 32'h0,        0, 0));
    // Backpressure fill then drain in order
    vecs.push_back(mk(0, 1, 0, 32'h11,       0, 1,  1, 1, 2'd1, 32'h11,       0, 1));
    vecs.push_back(mk(0, 1, 0, 32'h22,       1, 0,  1, 0, 2'd2, 32'h11,       0, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0,  1, 0, 2'd2, 32'h11,       0, 1));
    vecs.push_back(mk(0, 0, 1, 32'h0,        0, 0,  1, 1, 2'd1, 32'h22,       1, 0));
    vecs.push_back(mk(0, 0, 1, 32'h0,        0, 0,  0, 1, 2'd0, 32'h0,        0, 0));
    // Simultaneous in/out while holding one entry
    vecs.push_back(mk(0, 1, 0, 32'h1,        1, 0,  1, 1, 2'd1, 32'h1,        1, 0));
    vecs.push_back(mk(0, 1, 1, 32'h0,        0, 1,  1, 1, 2'd1, 32'h0,        0, 1));
    vecs.push_back(mk(0, 0, 1, 32'h0,        0, 0,  0, 1, 2'd0, 32'h0,        0, 0));
    // Side-effect gating after drain, main register still holds a store
    vecs.push_back(mk(0, 1, 0, 32'h55,       1, 1,  1, 1, 2'd1, 32'h55,       1, 1));
    vecs.push_back(mk(0, 0, 1, 32'h0,        0, 0,  0, 1, 2'd0, 32'h0,        0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0,  0, 1, 2'd0, 32'h0,        0, 0));
    // Flush while full with valid and ready both high
    vecs.push_back(mk(0, 1, 0, 32'hA,        1, 1,  1, 1, 2'd1, 32'hA,        1, 1));
    vecs.push_back(mk(0, 1, 0, 32'hB,        1, 1,  1, 0, 2'd2, 32'hA,        1, 1));
    vecs.push_back(mk(1, 1, 1, 32'hC,        1, 1,  0, 1, 2'd0, 32'h0,        0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h0,        0, 0,  0, 1, 2'd0, 32'h0,        0, 0));
    // Flush in ONE beats a coincident in_fire and out_fire
    vecs.push_back(mk(0, 1, 0, 32'hD,        1, 0,  1, 1, 2'd1, 32'hD,        1, 0));
    vecs.push_back(mk(1, 1, 1, 32'hE,        1, 0,  0, 1, 2'd0, 32'h0,        0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h0,        0, 0,  0, 1, 2'd0, 32'h0,        0, 0));

    @(negedge clk);
    @(negedge clk);
    chk("reset o_valid", 0, {31'd0, bus.o_valid}, 32'd0);
    chk("reset o_ready", 0, {31'd0, bus.o_ready}, 32'd1);
    chk("reset o_occupancy", 0, {30'd0, bus.o_occupancy}, 32'd0);
    chk("reset o_alu_result", 0, bus.o_alu_result, 32'd0);
    chk("reset o_rs2_data", 0, bus.o_rs2_data, 32'd0);
    chk("reset o_rd_wren", 0, {31'd0, bus.o_rd_wren}, 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].flush, vecs[i].valid, vecs[i].ready, vecs[i].alu, vecs[i].rdw, vecs[i].mw);
      @(posedge clk);
      #1;
      check_vec(i + 1, vecs[i]);
      @(negedge clk);
    end

    // Asynchronous reset between edges while full
    drive(1'b0, 1'b1, 1'b0, 32'h33, 1'b1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'h44, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    chk("full before reset o_occupancy", 100, {30'd0, bus.o_occupancy}, 32'd2);
    chk("full before reset o_alu_result", 100, bus.o_alu_result, 32'h33);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset o_valid", 101, {31'd0, bus.o_valid}, 32'd0);
    chk("async reset o_ready", 101, {31'd0, bus.o_ready}, 32'd1);
    chk("async reset o_occupancy", 101, {30'd0, bus.o_occupancy}, 32'd0);
    chk("async reset o_alu_result", 101, bus.o_alu_result, 32'd0);
    chk("async reset o_mem_wren", 101, {31'd0, bus.o_mem_wren}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 32'h66, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("after reset o_alu_result", 102, bus.o_alu_result, 32'h66);
    chk("after reset o_occupancy", 102, {30'd0, bus.o_occupancy}, 32'd1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("after reset drain o_valid", 103, {31'd0, bus.o_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
